logic_acc_4b: RTL and testbench

//   Registered operand/result stage for the 4-bit logic unit family (and/or/nand/nor/xor/xnor).

---
 rtl/logic_acc_4b_pkg.sv | 23 ++
 rtl/logic_acc_4b_if.sv | 28 ++
 rtl/logic_acc_4b_unit.sv | 25 ++
 rtl/logic_acc_4b.sv | 64 ++++++
 tb/tb_logic_acc_4b.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/logic_acc_4b_pkg.sv
// logic_acc_4b_pkg: shared width, opcode and output-state types for the 4-bit logic accumulator family.
package logic_acc_4b_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/logic_acc_4b_if.sv
// logic_acc_4b_if: operand-in / result-out handshake bundle of the logic accumulator stage.
interface logic_acc_4b_if;
    import logic_acc_4b_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    op_t              in_op;
    logic             in_acc_sel;
    logic             in_acc_wr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_o;
    logic             out_zero;
    logic [WIDTH-1:0] acc_o;

    modport master (
        output in_valid, in_x, in_y, in_op, in_acc_sel, in_acc_wr, out_ready,
        input  in_ready, out_valid, out_o, out_zero, acc_o
    );

    modport slave (
        input  in_valid, in_x, in_y, in_op, in_acc_sel, in_acc_wr, out_ready,
        output in_ready, out_valid, out_o, out_zero, acc_o
    );

endinterface

// File: rtl/logic_acc_4b_unit.sv
// logic_unit_4b: purely combinational bitwise logic unit, (a, b, op) -> y.
module logic_unit_4b
    import logic_acc_4b_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = b;
        endcase
    end

endmodule

// File: rtl/logic_acc_4b.sv
// logic_acc_4b: registered logic-op stage with one-entry output buffer and chaining accumulator.
// Define LOGIC_ACC_STATS_EN to add the saturating op_count accept counter port.
module logic_acc_4b
    import logic_acc_4b_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
`ifdef LOGIC_ACC_STATS_EN
    output logic [CNT_W-1:0]     op_count,
`endif
    logic_acc_4b_if.slave        bus
);

    ostate_t          state, state_nx;
    logic             ready, accept;
    logic [WIDTH-1:0] a, res, out_q, acc_q;
    logic             zero_q;

    // Operand a comes from the accumulator when chaining; it already holds the previous op's result.
    assign a = bus.in_acc_sel ? acc_q : bus.in_x;

    logic_unit_4b u_unit (
        .a  (a),
        .b  (bus.in_y),
        .op (bus.in_op),
        .y  (res)
    );

    always_comb begin
        ready    = (state == EMPTY) || bus.out_ready;
        accept   = bus.in_valid && ready;
        state_nx = accept ? FULL : (bus.out_ready ? EMPTY : state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            out_q  <= '0;
            zero_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_q  <= res;
                zero_q <= (res == '0);
                if (bus.in_acc_wr) acc_q <= res;
            end
        end
    end

`ifdef LOGIC_ACC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) op_count <= '0;
        else if (accept && op_count != '1) op_count <= op_count + 1'b1;
    end
`endif

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == FULL);
    assign bus.out_o     = out_q;
    assign bus.out_zero  = zero_q;
    assign bus.acc_o     = acc_q;

endmodule

// File: tb/tb_logic_acc_4b.sv
// tb_logic_acc_4b: directed plus randomized checks of logic_acc_4b against a truth-table reference model.
// Define LOGIC_ACC_STATS_EN to also check op_count.
module tb_logic_acc_4b;
    import logic_acc_4b_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_acc_4b_if bus ();
`ifdef LOGIC_ACC_STATS_EN
    logic [15:0] op_count;
`endif

    logic_acc_4b dut (
        .clk      (clk),
        .rst      (rst),
`ifdef LOGIC_ACC_STATS_EN
        .op_count (op_count),
`endif
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic       m_valid = 1'b0;
    logic [3:0] m_out = '0;
    logic       m_zero = 1'b0;
    logic [3:0] m_acc = '0;
    int         m_cnt = 0;

    // Per-op truth table indexed by {a_bit, b_bit}
    logic [3:0] tt [8];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] t, r;
        t = tt[op];
        for (int i = 0; i < 4; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] op, input logic sel, input logic wr, input logic ordy);
        logic       rdy, acc;
        logic [3:0] res;
        rst            = r;
        bus.in_valid   = v;
        bus.in_x       = x;
        bus.in_y       = y;
        bus.in_op      = op_t'(op);
        bus.in_acc_sel = sel;
        bus.in_acc_wr  = wr;
        bus.out_ready  = ordy;
        #3;
        rdy = !m_valid || ordy;
        if (!r) check("in_ready", {15'd0, bus.in_ready}, {15'd0, rdy});
        acc = v && rdy;
        res = ref_op(op, sel ? m_acc : x, y);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_out = 0; m_zero = 0; m_acc = 0; m_cnt = 0;
        end else if (acc) begin
            m_valid = 1; m_out = res; m_zero = (res == 0);
            if (wr) m_acc = res;
            if (m_cnt < 65535) m_cnt++;
        end else if (ordy) begin
            m_valid = 0;
        end
        check("out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
        check("out_o", {12'd0, bus.out_o}, {12'd0, m_out});
        check("out_zero", {15'd0, bus.out_zero}, {15'd0, m_zero});
        check("acc_o", {12'd0, bus.acc_o}, {12'd0, m_acc});
`ifdef LOGIC_ACC_STATS_EN
        check("op_count", op_count, 16'(m_cnt));
`endif
    endtask

    initial begin
        logic       pend, v, sel, wr, ordy, r;
        logic [3:0] x, y;
        logic [2:0] op;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1010;
        bus.in_valid = 0; bus.in_x = 0; bus.in_y = 0; bus.in_op = OP_AND;
        bus.in_acc_sel = 0; bus.in_acc_wr = 0; bus.out_ready = 1;
        @(posedge clk); #1;
        // Reset for two cycles, then idle to see in_ready=1
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check("reset_out_o", {12'd0, bus.out_o}, 16'h0000);
        // NAND, AND to zero, XOR
        cycle(0, 1, 4'b0001, 4'b0001, 3'b010, 0, 0, 1);
        check("nand_direct", {12'd0, bus.out_o}, 16'h000E);
        cycle(0, 1, 4'b1010, 4'b0101, 3'b000, 0, 0, 1);
        check("and_zero", {15'd0, bus.out_zero}, 16'h0001);
        cycle(0, 1, 4'b1010, 4'b0101, 3'b100, 0, 0, 1);
        check("xor_ones", {12'd0, bus.out_o}, 16'h000F);
        // Accumulator chaining back-to-back
        cycle(0, 1, 4'b0011, 4'b0101, 3'b001, 0, 1, 1);
        check("acc_written", {12'd0, bus.acc_o}, 16'h0007);
        cycle(0, 1, 4'b0000, 4'b0010, 3'b100, 1, 0, 1);
        check("acc_chain", {12'd0, bus.out_o}, 16'h0005);
        // Stall three cycles with a different bundle waiting, then release
        for (int i = 0; i < 3; i++) cycle(0, 1, 4'b1100, 4'b0110, 3'b011, 0, 1, 0);
        check("stall_hold", {12'd0, bus.out_o}, 16'h0005);
        cycle(0, 1, 4'b1100, 4'b0110, 3'b011, 0, 1, 1);
        check("after_stall", {12'd0, bus.out_o}, 16'h0001);
        // Reset while stalled full
        cycle(0, 1, 4'b1111, 4'b1111, 3'b111, 0, 1, 0);
        cycle(1, 1, 4'b1111, 4'b1111, 3'b111, 0, 1, 0);
        check("rst_stalled", {15'd0, bus.out_valid}, 16'h0000);
        // Randomized traffic; a bundle offered while not ready is held until accepted
        pend = 0; v = 0; x = 0; y = 0; op = 0; sel = 0; wr = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                x = 4'($urandom); y = 4'($urandom); op = 3'($urandom);
                sel = 1'($urandom); wr = 1'($urandom);
            end
            ordy = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 49) == 0);
            pend = v && !(!m_valid || ordy) && !r;
            cycle(r, v, x, y, op, sel, wr, ordy);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
